// File: rtl/fitness_bank.sv
// rtl/fitness_bank.sv - fitness array, saturated total and best tracker; FITNESS_BANK_WRCNT_EN adds wr_count
module fitness_bank #(
    parameter int FITNESS_WIDTH   = 14,
    parameter int POPULATION_SIZE = 16,
    parameter int ADDR_WIDTH      = $clog2(POPULATION_SIZE)
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          clear_start,
    input  logic                                          wr_en,
    input  logic [ADDR_WIDTH-1:0]                         wr_addr,
    input  logic [FITNESS_WIDTH-1:0]                      wr_fitness,
    output logic                                          wr_ready,
    output logic [POPULATION_SIZE-1:0][FITNESS_WIDTH-1:0] fitness_values,
    output logic [FITNESS_WIDTH-1:0]                      total_fitness,
    output logic [ADDR_WIDTH-1:0]                         best_index,
    output logic [FITNESS_WIDTH-1:0]                      best_fitness,
    output logic                                          bank_valid,
    output logic                                          busy
`ifdef FITNESS_BANK_WRCNT_EN
    ,
    output logic [15:0]                                   wr_count
`endif
);

    localparam int SUM_WIDTH = FITNESS_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(POPULATION_SIZE - 1);
    localparam logic [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'({FITNESS_WIDTH{1'b1}});

    typedef enum logic [1:0] {S_READY, S_CLEAR, S_RESCAN} state_t;

    state_t                                          r_state;
    state_t                                          w_next;
    logic [POPULATION_SIZE-1:0][FITNESS_WIDTH-1:0]   r_entries;
    logic [POPULATION_SIZE-1:0]                      r_written;
    logic [SUM_WIDTH-1:0]                            r_sum;
    logic [ADDR_WIDTH-1:0]                           r_best_idx;
    logic [FITNESS_WIDTH-1:0]                        r_best_val;
    logic [ADDR_WIDTH-1:0]                           r_idx;
    logic [ADDR_WIDTH-1:0]                           r_cand_idx;
    logic [FITNESS_WIDTH-1:0]                        r_cand_val;

    logic                                            w_wr_acc;
    logic                                            w_last;
    logic [FITNESS_WIDTH-1:0]                        w_old;
    logic                                            w_best_drop;
    logic [ADDR_WIDTH-1:0]                           w_scan_idx;
    logic [FITNESS_WIDTH-1:0]                        w_scan_val;

    assign wr_ready       = (r_state == S_READY) && !clear_start;
    assign w_wr_acc       = wr_en && wr_ready;
    assign w_last         = (r_idx == LAST_IDX);
    assign w_old          = r_entries[wr_addr];
    assign w_best_drop    = w_wr_acc && (wr_addr == r_best_idx) && (wr_fitness < w_old);
    assign fitness_values = r_entries;
    assign total_fitness  = (r_sum > SAT_MAX) ? {FITNESS_WIDTH{1'b1}} : r_sum[FITNESS_WIDTH-1:0];
    assign best_index     = r_best_idx;
    assign best_fitness   = r_best_val;
    assign bank_valid     = (&r_written) && (r_state == S_READY);
    assign busy           = (r_state != S_READY);

    // Rescan candidate after examining entry r_idx; the scan restarts at entry 0, strict '>' keeps lowest index on ties
    always_comb begin
        w_scan_idx = r_cand_idx;
        w_scan_val = r_cand_val;
        if (r_idx == '0) begin
            w_scan_idx = '0;
            w_scan_val = r_entries[0];
        end else if (r_entries[r_idx] > r_cand_val) begin
            w_scan_idx = r_idx;
            w_scan_val = r_entries[r_idx];
        end
    end

    // Next-state selection: clear wins over writes and aborts a rescan
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_READY: begin
                if (clear_start)      w_next = S_CLEAR;
                else if (w_best_drop) w_next = S_RESCAN;
            end
            S_CLEAR: begin
                if (w_last) w_next = S_READY;
            end
            S_RESCAN: begin
                if (clear_start) w_next = S_CLEAR;
                else if (w_last) w_next = S_READY;
            end
            default: w_next = S_READY;
        endcase
    end

    // State register and step counter; the counter restarts on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_READY;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || (r_state == S_READY)) r_idx <= '0;
            else                                              r_idx <= r_idx + 1'b1;
        end
    end

    // Entry array, exact sum, written mask and best tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entries  <= '0;
            r_written  <= '0;
            r_sum      <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
            r_cand_idx <= '0;
            r_cand_val <= '0;
        end else begin
            case (r_state)
                S_READY: begin
                    if (w_wr_acc) begin
                        r_entries[wr_addr] <= wr_fitness;
                        r_written[wr_addr] <= 1'b1;
                        r_sum              <= r_sum - SUM_WIDTH'(w_old) + SUM_WIDTH'(wr_fitness);
                        if (!w_best_drop) begin
                            if (wr_fitness > r_best_val) begin
                                r_best_idx <= wr_addr;
                                r_best_val <= wr_fitness;
                            end else if (wr_addr == r_best_idx) begin
                                r_best_val <= wr_fitness;
                            end
                        end
                    end
                end
                S_CLEAR: begin
                    r_entries[r_idx] <= '0;
                    if (w_last) begin
                        r_sum      <= '0;
                        r_best_idx <= '0;
                        r_best_val <= '0;
                        r_written  <= '0;
                    end
                end
                S_RESCAN: begin
                    if (!clear_start) begin
                        r_cand_idx <= w_scan_idx;
                        r_cand_val <= w_scan_val;
                        if (w_last) begin
                            r_best_idx <= w_scan_idx;
                            r_best_val <= w_scan_val;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FITNESS_BANK_WRCNT_EN
    logic [15:0] r_wr_count;
    assign wr_count = r_wr_count;

    // Accepted-write counter, wraps naturally, cleared when a clear completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_wr_count <= '0;
        else if (w_wr_acc)                   r_wr_count <= r_wr_count + 16'd1;
        else if (r_state == S_CLEAR && w_last) r_wr_count <= '0;
    end
`endif

endmodule
